fourteen_to_one_serializer: RTL and testbench
=============================================

Name: fourteen_to_one_serializer

Overview:
FSM-based 14-to-1 parallel-to-serial transmitter. It is the transmit end of the serial link fed into the existing 1-to-14 deserializer.
- Accepts a 14-bit word on a load strobe.
- Emits a one-cycle start strobe (ss), then shifts the word out MSB-first, one bit per clock.
- Holds in a done state until the far end acknowledges (Ack).
- Exposes present/next FSM state for LED debug, matching the board-level debug style.

Parameters:
WIDTH, 14, number of data bits per frame (shift length)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W >= WIDTH+1

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset, sampled on rising edge of clock
load  input  1  parallel-load request; honoured only in IDLE
data_in  input  WIDTH  parallel word, captured when load is accepted
Ack  input  1  receiver acknowledge; honoured only in DONE
ss  output  1  start strobe; high for exactly the one START cycle
data_out  output  1  serial data bit
ready  output  1  high in IDLE (a load will be accepted)
done  output  1  high in DONE (frame sent, awaiting Ack)
y_Q  output  2  present state encoding
Y_D  output  2  next state encoding (combinational)

Behaviour:
- State encoding: IDLE=2'b00, START=2'b01, SHIFT=2'b10, DONE=2'b11. y_Q is the state register; Y_D is the combinational next-state value.
- Reset: resetn=0 at a rising edge forces state=IDLE, shift register=0, bit counter=0. After reset: ss=0, data_out=0, ready=1, done=0, y_Q=00. Reset mid-frame aborts the frame immediately; no partial bits follow.
- IDLE:
  - ready=1.
  - load=1 at an edge: capture data_in into the shift register, clear the counter, go to START.
  - load=0: stay in IDLE.
- START: one cycle only. ss=1, data_out=0, then unconditionally go to SHIFT.
- SHIFT:
  - data_out = shreg[WIDTH-1].
  - Each edge: shift left (fill 0) and counter += 1.
  - When counter == WIDTH-1 at an edge, go to DONE.
  - Stays exactly WIDTH cycles in SHIFT.
- DONE:
  - done=1, data_out=0.
  - Ack=1 at an edge: go to IDLE.
  - Ack=0: stay in DONE indefinitely.
- Outputs are decoded from the registered state, so they are glitch-free relative to y_Q. data_out=0 in every state except SHIFT.
- Latency: load accepted at edge k → ss=1 during cycle k+1 → bit WIDTH-1 during cycle k+2 … bit 0 during cycle k+WIDTH+1 → done=1 from cycle k+WIDTH+2.
- Ignored inputs:
  - load outside IDLE is ignored; data_in is not re-captured.
  - Ack outside DONE is ignored, including Ack held high from before the frame.
  - load and Ack asserted together in DONE: Ack wins and the state goes to IDLE. That load is not captured; a fresh load in IDLE is required.
- Back-to-back frames: minimum frame period is WIDTH+3 cycles (START + WIDTH + DONE with Ack=1 + IDLE).

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- Defined:
  - SHIFT lasts WIDTH+1 cycles. The extra final bit is even parity (XOR of the captured data_in), computed at load and driven in the cycle after bit 0.
  - done asserts one cycle later than without the macro.
  - CNT_W must satisfy 2**CNT_W >= WIDTH+2.
- Undefined: no parity logic; behaviour exactly as above.

Test Plan:
1. Reset: resetn=0 for 2 cycles while load=1 and data_in=14'h3FFF → y_Q=00, ready=1, ss=0, done=0, data_out=0; no frame starts.
2. Single frame: load=1 with data_in=14'h2A5C (one cycle), Ack=0 → ss=1 for one cycle, then data_out sequence 1,0,1,0,1,0,0,1,0,1,1,1,0,0 over 14 cycles, then done=1 and y_Q=11 held; Ack=1 → next cycle y_Q=00, ready=1.
3. Ignored strobes: load pulsed with 14'h0001 during SHIFT of a 14'h2000 frame, and Ack=1 held during SHIFT → serial stream is 1 followed by 13 zeros; DONE is still entered and exits only on Ack at or after its first cycle.
4. Reset mid-frame: load 14'h3FFF, assert resetn=0 after 5 data bits → next cycle y_Q=00, data_out=0, ready=1; a subsequent load of 14'h0003 sends 12 zeros then 1,1.
5. Y_D check: in IDLE with load=1, Y_D=01 while y_Q=00; in DONE with Ack=1, Y_D=00 while y_Q=11.
6. With SERIALIZER_PARITY_EN: load 14'h2A5C → 14 data bits as in scenario 2 followed by parity bit 1, then done=1.

Source files
------------

// File: rtl/fourteen_to_one_serializer.sv
// rtl/fourteen_to_one_serializer.sv - FSM-based 14-to-1 parallel-to-serial transmitter
//
// Purpose:
//   Transmit end of the serial link that feeds the 1-to-14 deserializer.
//   A word is captured on a load strobe in IDLE. A one-cycle start strobe
//   follows, and then the word is shifted out MSB-first, one bit per clock.
//   The block then holds in DONE until the far end acknowledges.
//
// Optional feature macro: SERIALIZER_PARITY_EN
//   When defined, an even-parity bit (XOR of the captured word) is sent
//   after bit 0, so SHIFT lasts WIDTH+1 cycles. CNT_W must then satisfy
//   2**CNT_W >= WIDTH+2.
//
// Ports:
//   clock     in   system clock, rising edge
//   resetn    in   synchronous active-low reset
//   load      in   parallel-load request, honoured only in IDLE
//   data_in   in   [WIDTH] parallel word, captured when load is accepted
//   Ack       in   receiver acknowledge, honoured only in DONE
//   ss        out  start strobe, high for the single START cycle
//   data_out  out  serial data bit (0 outside SHIFT)
//   ready     out  high in IDLE
//   done      out  high in DONE
//   y_Q       out  [2] present state (IDLE=00 START=01 SHIFT=10 DONE=11)
//   Y_D       out  [2] next state, combinational (LED debug)

module fourteen_to_one_serializer #(
    parameter int WIDTH = 14,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             Ack,
    output logic             ss,
    output logic             data_out,
    output logic             ready,
    output logic             done,
    output logic [1:0]       y_Q,
    output logic [1:0]       Y_D
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

`ifdef SERIALIZER_PARITY_EN
    localparam int SHIFT_LEN = WIDTH + 1;
`else
    localparam int SHIFT_LEN = WIDTH;
`endif

    // Counter value seen during the final SHIFT cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_LEN - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

`ifdef SERIALIZER_PARITY_EN
    logic             parity_q, parity_d;
    // The parity bit goes out once all WIDTH data bits have been sent.
    localparam logic [CNT_W-1:0] PARITY_CNT = CNT_W'(WIDTH);
`endif

    // Next-state, shift register and counter update.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d  = ST_START;
                    shreg_d  = data_in;
                    cnt_d    = '0;
`ifdef SERIALIZER_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            ST_START: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Ack wins over a simultaneous load; that load is dropped.
                if (Ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so they never glitch with inputs.
    always_comb begin
        ss       = 1'b0;
        data_out = 1'b0;
        ready    = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE:  ready = 1'b1;
            ST_START: ss    = 1'b1;
            ST_SHIFT: begin
`ifdef SERIALIZER_PARITY_EN
                if (cnt_q == PARITY_CNT) begin
                    data_out = parity_q;
                end else begin
                    data_out = shreg_q[WIDTH-1];
                end
`else
                data_out = shreg_q[WIDTH-1];
`endif
            end
            ST_DONE:  done  = 1'b1;
            default:  ready = 1'b0;
        endcase
    end

    assign y_Q = state_q;
    assign Y_D = state_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_fourteen_to_one_serializer.sv
// tb/tb_fourteen_to_one_serializer.sv - scoreboard testbench for fourteen_to_one_serializer

module tb_fourteen_to_one_serializer;

    localparam int WIDTH = 14;
`ifdef SERIALIZER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             resetn;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             Ack;
    logic             ss;
    logic             data_out;
    logic             ready;
    logic             done;
    logic [1:0]       y_Q;
    logic [1:0]       Y_D;

    fourteen_to_one_serializer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .data_in  (data_in),
        .Ack      (Ack),
        .ss       (ss),
        .data_out (data_out),
        .ready    (ready),
        .done     (done),
        .y_Q      (y_Q),
        .Y_D      (Y_D)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NB-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the serial stream a word should produce, first bit at the MSB.
    function automatic logic [NB-1:0] frame_bits(input logic [WIDTH-1:0] d);
        logic [NB-1:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[NB-1-i] = (int'(d) >> (WIDTH - 1 - i)) % 2 == 1;
        end
`ifdef SERIALIZER_PARITY_EN
        s[0] = ($countones(d) % 2) == 1;
`endif
        return s;
    endfunction

    // Monitor: on each start strobe pop the expected stream and compare the
    // following NB serial bits, then expect done.
    logic [NB-1:0] cur;
    int  bit_idx   = 0;
    bit  in_frame  = 0;
    bit  want_done = 0;

    always @(negedge clock) begin
        if (resetn !== 1'b1) begin
            in_frame  = 0;
            want_done = 0;
        end else if (want_done) begin
            chk("done_after_frame", {31'd0, done}, 32'd1);
            want_done = 0;
        end else if (in_frame) begin
            chk("serial_bit", {31'd0, data_out}, {31'd0, cur[NB-1-bit_idx]});
            if (bit_idx == 0) chk("ss_one_cycle", {31'd0, ss}, 32'd0);
            bit_idx++;
            if (bit_idx == NB) begin
                in_frame  = 0;
                want_done = 1;
            end
        end else if (ss === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_start: got ss=1 expected no frame at %0t", $time);
            end else begin
                cur      = exp_q.pop_front();
                in_frame = 1;
                bit_idx  = 0;
                chk("start_data_out", {31'd0, data_out}, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (ready !== 1'b1) chk("wait_ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d);
        wait_ready();
        @(posedge clock);
        #1;
        load    = 1'b1;
        data_in = d;
        exp_q.push_back(frame_bits(d));
        @(negedge clock);
        chk("idle_y_Q", {30'd0, y_Q}, 32'd0);
        chk("idle_load_Y_D", {30'd0, Y_D}, 32'd1);
        @(posedge clock);
        #1;
        load    = 1'b0;
        data_in = WIDTH'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clock);
        while (done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) chk("wait_done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic ack_and_check();
        @(posedge clock);
        #1;
        Ack = 1'b1;
        @(negedge clock);
        chk("done_ack_y_Q", {30'd0, y_Q}, 32'd3);
        chk("done_ack_Y_D", {30'd0, Y_D}, 32'd0);
        @(posedge clock);
        #1;
        Ack = 1'b0;
        @(negedge clock);
        chk("after_ack_y_Q", {30'd0, y_Q}, 32'd0);
        chk("after_ack_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        resetn  = 1'b0;
        load    = 1'b1;
        data_in = 14'h3FFF;
        Ack     = 1'b0;

        // Reset with load asserted: no frame may start.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_y_Q", {30'd0, y_Q}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_ss", {31'd0, ss}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data_out", {31'd0, data_out}, 32'd0);
        @(posedge clock);
        #1;
        load   = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_idle", {30'd0, y_Q}, 32'd0);

        // Single frame, DONE held without Ack.
        send_frame(14'h2A5C);
        wait_done();
        repeat (3) @(negedge clock);
        chk("done_hold_y_Q", {30'd0, y_Q}, 32'd3);
        chk("done_hold_done", {31'd0, done}, 32'd1);
        ack_and_check();

        // Ignored load during SHIFT and Ack held from before the frame.
        Ack = 1'b1;
        send_frame(14'h2000);
        repeat (4) @(posedge clock);
        #1;
        load    = 1'b1;
        data_in = 14'h0001;
        @(posedge clock);
        #1;
        load = 1'b0;
        wait_done();
        @(negedge clock);
        chk("held_ack_exit", {30'd0, y_Q}, 32'd0);
        @(posedge clock);
        #1;
        Ack = 1'b0;
        repeat (3) @(negedge clock);
        chk("no_stray_frame", {31'd0, ready}, 32'd1);

        // Load and Ack together in DONE: Ack wins, load not captured.
        send_frame(14'h1234);
        wait_done();
        @(posedge clock);
        #1;
        load    = 1'b1;
        Ack     = 1'b1;
        data_in = 14'h3C3C;
        @(posedge clock);
        #1;
        load = 1'b0;
        Ack  = 1'b0;
        repeat (3) @(negedge clock);
        chk("ack_beats_load", {30'd0, y_Q}, 32'd0);

        // Reset mid-frame.
        send_frame(14'h3FFF);
        repeat (6) @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("midrst_y_Q", {30'd0, y_Q}, 32'd0);
        chk("midrst_data_out", {31'd0, data_out}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        send_frame(14'h0003);
        wait_done();
        ack_and_check();

        // Randomized frames with stray loads and random Ack delay.
        for (int f = 0; f < 20; f++) begin
            send_frame(WIDTH'($urandom));
            repeat (3) @(posedge clock);
            #1;
            load    = 1'($urandom % 2);
            data_in = WIDTH'($urandom);
            @(posedge clock);
            #1;
            load = 1'b0;
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clock);
            ack_and_check();
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
